// File: rtl/keyboard_input_decoder_if.sv
// rtl/keyboard_input_decoder_if.sv - PS/2 byte strobe in, per-player movement/bomb signals out
interface keyboard_input_decoder_if;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;
    logic       p1_xdir;
    logic       p1_xmov;
    logic       p1_ydir;
    logic       p1_ymov;
    logic       p1_bomb;
    logic       p2_xdir;
    logic       p2_xmov;
    logic       p2_ydir;
    logic       p2_ymov;
    logic       p2_bomb;
    logic [9:0] keys_held;

    modport master (
        output ps2_byte, ps2_byte_valid,
        input  p1_xdir, p1_xmov, p1_ydir, p1_ymov, p1_bomb,
        input  p2_xdir, p2_xmov, p2_ydir, p2_ymov, p2_bomb,
        input  keys_held
    );

    modport slave (
        input  ps2_byte, ps2_byte_valid,
        output p1_xdir, p1_xmov, p1_ydir, p1_ymov, p1_bomb,
        output p2_xdir, p2_xmov, p2_ydir, p2_ymov, p2_bomb,
        output keys_held
    );
endinterface

// File: rtl/keyboard_input_decoder.sv
// rtl/keyboard_input_decoder.sv - PS/2 scan-code decoder to game key state and movement levels
// Optional PREFIX_TIMEOUT_EN abandons a stalled F0/E0 prefix after TIMEOUT_CYCLES clocks.
module keyboard_input_decoder
`ifdef PREFIX_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 50000
)
`endif
(
    input logic                     clock,
    input logic                     reset,
    keyboard_input_decoder_if.slave kb
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BREAK,
        S_EXT_BREAK
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       key_act;
    logic       key_make;
    logic       key_ext;
    logic       key_hit;
    logic [3:0] key_idx;
    logic       is_ctrl;
    logic [9:0] keys_next;
    logic [7:0] b;

    assign b = kb.ps2_byte;

    // Keyboard protocol responses carry no key information and resync the decoder.
    assign is_ctrl = (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
                     (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);

`ifdef PREFIX_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge clock) begin
        if (reset || kb.ps2_byte_valid || state_next == S_IDLE) begin
            tmo_cnt <= 16'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        key_act    = 1'b0;
        key_make   = 1'b0;
        key_ext    = 1'b0;
        if (kb.ps2_byte_valid) begin
            if (is_ctrl) begin
                state_next = S_IDLE;
            end else if (b == 8'hE0) begin
                state_next = S_EXT;
            end else if (b == 8'hF0) begin
                state_next = (state == S_EXT || state == S_EXT_BREAK) ? S_EXT_BREAK : S_BREAK;
            end else begin
                key_act    = 1'b1;
                key_make   = (state == S_IDLE) || (state == S_EXT);
                key_ext    = (state == S_EXT) || (state == S_EXT_BREAK);
                state_next = S_IDLE;
            end
        end
`ifdef PREFIX_TIMEOUT_EN
        else if (state != S_IDLE && tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state_next = S_IDLE;
        end
`endif
    end

    // Index follows the keys_held bit order.
    always_comb begin
        key_hit = 1'b1;
        key_idx = 4'd0;
        case ({key_ext, b})
            9'h01D:  key_idx = 4'd0;
            9'h01B:  key_idx = 4'd1;
            9'h01C:  key_idx = 4'd2;
            9'h023:  key_idx = 4'd3;
            9'h029:  key_idx = 4'd4;
            9'h175:  key_idx = 4'd5;
            9'h172:  key_idx = 4'd6;
            9'h16B:  key_idx = 4'd7;
            9'h174:  key_idx = 4'd8;
            9'h05A:  key_idx = 4'd9;
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        keys_next = kb.keys_held;
        if (key_act && key_hit) begin
            keys_next[key_idx] = key_make;
        end
    end

    // Movement is registered from keys_next so every output lands one clock after the strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            kb.keys_held <= 10'd0;
            kb.p1_bomb   <= 1'b0;
            kb.p2_bomb   <= 1'b0;
            kb.p1_xmov   <= 1'b0;
            kb.p1_ymov   <= 1'b0;
            kb.p1_xdir   <= 1'b0;
            kb.p1_ydir   <= 1'b0;
            kb.p2_xmov   <= 1'b0;
            kb.p2_ymov   <= 1'b0;
            kb.p2_xdir   <= 1'b0;
            kb.p2_ydir   <= 1'b0;
        end else begin
            kb.keys_held <= keys_next;
            kb.p1_bomb   <= key_act && key_make && key_hit && (key_idx == 4'd4) && !kb.keys_held[4];
            kb.p2_bomb   <= key_act && key_make && key_hit && (key_idx == 4'd9) && !kb.keys_held[9];

            kb.p1_xmov <= keys_next[2] ^ keys_next[3];
            kb.p1_ymov <= keys_next[0] ^ keys_next[1];
            if (keys_next[3] && !keys_next[2]) kb.p1_xdir <= 1'b1;
            else if (keys_next[2] && !keys_next[3]) kb.p1_xdir <= 1'b0;
            if (keys_next[1] && !keys_next[0]) kb.p1_ydir <= 1'b1;
            else if (keys_next[0] && !keys_next[1]) kb.p1_ydir <= 1'b0;

            kb.p2_xmov <= keys_next[7] ^ keys_next[8];
            kb.p2_ymov <= keys_next[5] ^ keys_next[6];
            if (keys_next[8] && !keys_next[7]) kb.p2_xdir <= 1'b1;
            else if (keys_next[7] && !keys_next[8]) kb.p2_xdir <= 1'b0;
            if (keys_next[6] && !keys_next[5]) kb.p2_ydir <= 1'b1;
            else if (keys_next[5] && !keys_next[6]) kb.p2_ydir <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keyboard_input_decoder.sv
// tb/tb_keyboard_input_decoder.sv - directed scoreboard bench for keyboard_input_decoder
module tb_keyboard_input_decoder;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    keyboard_input_decoder_if kb ();

`ifdef PREFIX_TIMEOUT_EN
    keyboard_input_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clock (clock),
        .reset (reset),
        .kb    (kb.slave)
    );
`else
    keyboard_input_decoder dut (
        .clock (clock),
        .reset (reset),
        .kb    (kb.slave)
    );
`endif

    typedef struct {
        logic [19:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // {xdir, xmov, ydir, ymov, bomb} per player, then keys_held
    function automatic logic [19:0] observed();
        return {kb.p1_xdir, kb.p1_xmov, kb.p1_ydir, kb.p1_ymov, kb.p1_bomb,
                kb.p2_xdir, kb.p2_xmov, kb.p2_ydir, kb.p2_ymov, kb.p2_bomb,
                kb.keys_held};
    endfunction

    task automatic push(input logic [9:0] k, input logic [4:0] e1, input logic [4:0] e2, input string tag);
        exp_t e;
        e.v   = {e1, e2, k};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [19:0] obs;
        e   = sb.pop_front();
        obs = observed();
        n_assert++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [9:0] k,
                        input logic [4:0] e1, input logic [4:0] e2, input string tag);
        push(k, e1, e2, tag);
        kb.ps2_byte       = b;
        kb.ps2_byte_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        kb.ps2_byte_valid = 1'b0;
        pop_check();
    endtask

    task automatic idle(input logic [9:0] k, input logic [4:0] e1, input logic [4:0] e2, input string tag);
        push(k, e1, e2, tag);
        @(posedge clock);
        @(negedge clock);
        pop_check();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        kb.ps2_byte       = 8'h00;
        kb.ps2_byte_valid = 1'b0;
        @(negedge clock);
        do_reset();
        idle(10'h000, 5'b00000, 5'b00000, "reset_state");

        // P1 up make/break
        send(8'h1D, 10'h001, 5'b00010, 5'b00000, "w_make");
        send(8'hF0, 10'h001, 5'b00010, 5'b00000, "w_f0_prefix");
        send(8'h1D, 10'h000, 5'b00000, 5'b00000, "w_break");

        // P2 right, then left also, then release right
        send(8'hE0, 10'h000, 5'b00000, 5'b00000, "e0_prefix");
        send(8'h74, 10'h100, 5'b00000, 5'b11000, "p2_right");
        send(8'hE0, 10'h100, 5'b00000, 5'b11000, "e0_prefix2");
        send(8'h6B, 10'h180, 5'b00000, 5'b10000, "p2_left_both");
        send(8'hE0, 10'h180, 5'b00000, 5'b10000, "e0_prefix3");
        send(8'hF0, 10'h180, 5'b00000, 5'b10000, "ext_f0_prefix");
        send(8'h74, 10'h080, 5'b00000, 5'b01000, "p2_right_break");

        // Bomb typematic
        send(8'h29, 10'h090, 5'b00001, 5'b01000, "bomb_first");
        idle(10'h090, 5'b00000, 5'b01000, "bomb_width");
        send(8'h29, 10'h090, 5'b00000, 5'b01000, "bomb_repeat1");
        send(8'h29, 10'h090, 5'b00000, 5'b01000, "bomb_repeat2");
        send(8'hF0, 10'h090, 5'b00000, 5'b01000, "bomb_f0");
        send(8'h29, 10'h080, 5'b00000, 5'b01000, "bomb_break");
        send(8'h29, 10'h090, 5'b00001, 5'b01000, "bomb_second");
        idle(10'h090, 5'b00000, 5'b01000, "bomb_width2");

        // Wrong-form and control bytes
        send(8'hE0, 10'h090, 5'b00000, 5'b01000, "e0_then_w");
        send(8'h1D, 10'h090, 5'b00000, 5'b01000, "ext_w_ignored");
        send(8'hE0, 10'h090, 5'b00000, 5'b01000, "e0_then_ack");
        send(8'hAA, 10'h090, 5'b00000, 5'b01000, "ctrl_aa");
        send(8'h75, 10'h090, 5'b00000, 5'b01000, "75_after_ctrl");

        // Reset mid-prefix discards E0
        do_reset();
        idle(10'h000, 5'b00000, 5'b00000, "reset_clears");
        send(8'hE0, 10'h000, 5'b00000, 5'b00000, "e0_before_reset");
        do_reset();
        send(8'h75, 10'h000, 5'b00000, 5'b00000, "75_after_reset");

        // Strobe coincident with reset is dropped
        push(10'h000, 5'b00000, 5'b00000, "strobe_during_reset");
        reset             = 1'b1;
        kb.ps2_byte       = 8'h1D;
        kb.ps2_byte_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset             = 1'b0;
        kb.ps2_byte_valid = 1'b0;
        pop_check();
        idle(10'h000, 5'b00000, 5'b00000, "after_dropped_strobe");

        // Back-to-back strobes
        send(8'h23, 10'h008, 5'b11000, 5'b00000, "b2b_d_make");
        send(8'hE0, 10'h008, 5'b11000, 5'b00000, "b2b_e0");
        send(8'h72, 10'h048, 5'b11000, 5'b00110, "b2b_down");
        send(8'hF0, 10'h048, 5'b11000, 5'b00110, "b2b_f0");
        send(8'h23, 10'h040, 5'b10000, 5'b00110, "b2b_d_break");

        // P2 bomb; extended form of Enter must not match
        send(8'h5A, 10'h240, 5'b10000, 5'b00111, "p2_bomb");
        idle(10'h240, 5'b10000, 5'b00110, "p2_bomb_width");
        send(8'hE0, 10'h240, 5'b10000, 5'b00110, "e0_enter");
        send(8'h5A, 10'h240, 5'b10000, 5'b00110, "ext_enter_ignored");

        // Stalled break prefix
        do_reset();
        send(8'hF0, 10'h000, 5'b00000, 5'b00000, "stall_f0");
        repeat (20) @(negedge clock);
`ifdef PREFIX_TIMEOUT_EN
        send(8'h1C, 10'h004, 5'b01000, 5'b00000, "timeout_make");
`else
        send(8'h1C, 10'h000, 5'b00000, 5'b00000, "no_timeout_break");
`endif

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
